// File: rtl/ahbl_i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_i2s_tx_pkg
// Description : Shared constants for the AHB-Lite I2S transmitter: register
//               offsets, CTRL/STATUS bit positions, unmapped read value and
//               the CTRL register record.
// Revision    : 1.0 - initial release
// ============================================================================
package ahbl_i2s_tx_pkg;

  // Register offsets (decoded on HADDR[7:0])
  localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
  localparam logic [7:0] c_ADDR_STATUS = 8'h04;
  localparam logic [7:0] c_ADDR_DATA   = 8'h08;

  // CTRL bit positions
  localparam int c_CTRL_EN    = 0;
  localparam int c_CTRL_MONO  = 1;
  localparam int c_CTRL_IE    = 2;
  localparam int c_CTRL_FLUSH = 3;

  // STATUS bit positions
  localparam int c_ST_EMPTY     = 0;
  localparam int c_ST_FULL      = 1;
  localparam int c_ST_UNDERRUN  = 2;
  localparam int c_ST_OVERFLOW  = 3;
  localparam int c_ST_LEVEL_LSB = 4;
  localparam int c_ST_LEVEL_W   = 5;

  // Value returned by reads of unmapped offsets
  localparam logic [31:0] c_UNMAPPED_RD = 32'hBADD_BEEF;

  // Persistent CTRL fields (FLUSH is a pulse and is held separately)
  typedef struct packed {
    logic ie;
    logic mono;
    logic en;
  } ctrl_t;

endpackage : ahbl_i2s_tx_pkg
`default_nettype wire

// File: rtl/ahbl_i2s_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_core
// Description : I2S master serializer. Divides clk into SCK, tracks the bit
//               index and channel, drives WS one SCK ahead of each slot MSB
//               and shifts slot words out MSB-first on SD. Pulls slot words
//               from an external FIFO through a pop/empty handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   i_en          in   run enable; low holds everything in reset state
//   i_mono        in   1: one FIFO word feeds both slots of a frame
//   i_fifo_empty  in   FIFO has no word available
//   i_fifo_data   in   FIFO head word
//   o_pop         out  consume the FIFO head this cycle
//   o_underrun    out  a slot needed a word but the FIFO was empty
//   o_sck         out  I2S bit clock
//   o_ws          out  I2S word select (0 = left, 1 = right)
//   o_sd          out  I2S serial data
// ============================================================================
module i2s_tx_core #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_mono,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_pop,
  output logic        o_underrun,
  output logic        o_sck,
  output logic        o_ws,
  output logic        o_sd
);

  localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

  // Idle state parks the bit index at 31 and the channel at "right", so the
  // very first falling edge after enabling is a left-slot start.
  localparam logic [4:0] c_IDX_IDLE = 5'd31;

  logic [7:0]  r_div;
  logic        r_sck;
  logic        r_ws;
  logic        r_sd;
  logic        r_chan;   // channel of the slot being shifted (1 = right)
  logic [4:0]  r_idx;
  logic [31:0] r_shift;
  logic [31:0] r_word;   // last word loaded at a pop point (reused for MONO)

  logic        w_tick;
  logic        w_fall;
  logic        w_slot;
  logic        w_need_pop;
  logic [31:0] w_load;

  assign w_tick = (r_div == c_DIV_LAST);
  assign w_fall = w_tick & r_sck;
  assign w_slot = w_fall & (r_idx == 5'd31);

  // Next slot is left when the current one is right. In MONO only the left
  // slot fetches; the right slot repeats the stored word.
  assign w_need_pop = w_slot & (~i_mono | r_chan);

  always_comb begin
    w_load = r_word;
    if (w_need_pop) begin
      w_load = i_fifo_empty ? 32'h0 : i_fifo_data;
    end
  end

  assign o_pop      = i_en & w_need_pop & ~i_fifo_empty;
  assign o_underrun = i_en & w_need_pop &  i_fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= 8'd0;
      r_sck   <= 1'b0;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
      r_chan  <= 1'b1;
      r_idx   <= c_IDX_IDLE;
      r_shift <= 32'h0;
      r_word  <= 32'h0;
    end else if (!i_en) begin
      r_div   <= 8'd0;
      r_sck   <= 1'b0;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
      r_chan  <= 1'b1;
      r_idx   <= c_IDX_IDLE;
      r_shift <= 32'h0;
      r_word  <= 32'h0;
    end else begin
      if (w_tick) begin
        r_div <= 8'd0;
        r_sck <= ~r_sck;
      end else begin
        r_div <= r_div + 8'd1;
      end

      if (w_fall) begin
        r_idx <= r_idx + 5'd1;
        // WS changes while the last bit of the current slot is on SD
        if (r_idx == 5'd30) begin
          r_ws <= ~r_ws;
        end
        if (w_slot) begin
          r_shift <= w_load;
          r_sd    <= w_load[31];
          r_chan  <= ~r_chan;
          if (w_need_pop) begin
            r_word <= w_load;
          end
        end else begin
          r_shift <= {r_shift[30:0], 1'b0};
          r_sd    <= r_shift[30];
        end
      end
    end
  end

  assign o_sck = r_sck;
  assign o_ws  = r_ws;
  assign o_sd  = r_sd;

endmodule : i2s_tx_core
`default_nettype wire

// File: rtl/ahbl_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_i2s_tx
// Description : AHB-Lite slave I2S master transmitter. CPU writes 32-bit slot
//               words into a FIFO; the serializer core plays them out in
//               standard I2S framing (left while WS=0, right while WS=1).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   HCLK       in   system clock
//   HRESETn    in   asynchronous active-low reset
//   HADDR      in   AHB address (offset decoded on [7:0])
//   HTRANS     in   AHB transfer type
//   HWRITE     in   AHB write
//   HSIZE      in   AHB size (ignored, word access only)
//   HWDATA     in   AHB write data
//   HSEL       in   slave select
//   HREADY     in   bus ready
//   HRDATA     out  read data
//   HREADYOUT  out  always 1
//   SCK/WS/SD  out  I2S bit clock, word select, serial data
//   IRQ        out  level interrupt: IE & EN & (EMPTY | UNDERRUN)
// Registers: CTRL 0x00 (EN, MONO, IE, FLUSH), STATUS 0x04, DATA 0x08
// ============================================================================
module ahbl_i2s_tx
  import ahbl_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        SCK,
  output logic        WS,
  output logic        SD,
  output logic        IRQ
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  typedef logic [c_AW-1:0] ptr_t;
  typedef logic [c_AW:0]   cnt_t;

  localparam cnt_t c_FULL_CNT = cnt_t'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Address phase capture
  // --------------------------------------------------------------------------
  logic [7:0] r_haddr;
  logic       r_htrans_act;
  logic       r_hwrite;
  logic       r_hsel;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr      <= 8'h0;
      r_htrans_act <= 1'b0;
      r_hwrite     <= 1'b0;
      r_hsel       <= 1'b0;
    end else if (HREADY) begin
      r_haddr      <= HADDR[7:0];
      r_htrans_act <= HTRANS[1];
      r_hwrite     <= HWRITE;
      r_hsel       <= HSEL;
    end
  end

  logic w_wr;
  logic w_rd;
  logic w_wr_ctrl;
  logic w_wr_data;
  logic w_rd_status;

  assign w_wr        = r_htrans_act & r_hsel &  r_hwrite;
  assign w_rd        = r_htrans_act & r_hsel & ~r_hwrite;
  assign w_wr_ctrl   = w_wr & (r_haddr == c_ADDR_CTRL);
  assign w_wr_data   = w_wr & (r_haddr == c_ADDR_DATA);
  assign w_rd_status = w_rd & (r_haddr == c_ADDR_STATUS);

  // Upper address bits, IDLE/BUSY distinction and size carry no information
  logic w_unused;
  assign w_unused = ^{HADDR[31:8], HTRANS[0], HSIZE};

  // --------------------------------------------------------------------------
  // CTRL
  // --------------------------------------------------------------------------
  ctrl_t r_ctrl;
  logic  r_flush;   // one-cycle pulse following a FLUSH write

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ctrl  <= '0;
      r_flush <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_ctrl.en   <= HWDATA[c_CTRL_EN];
      r_ctrl.mono <= HWDATA[c_CTRL_MONO];
      r_ctrl.ie   <= HWDATA[c_CTRL_IE];
      r_flush     <= HWDATA[c_CTRL_FLUSH];
    end else begin
      r_flush <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [31:0] r_mem [FIFO_DEPTH];
  ptr_t        r_wptr;
  ptr_t        r_rptr;
  cnt_t        r_count;

  logic w_empty;
  logic w_full;
  logic w_core_pop;
  logic w_core_urun;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_ovf_set;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL_CNT);
  // The flush pulse wins over both a concurrent pop and a concurrent push
  assign w_pop      = w_core_pop & ~r_flush;
  assign w_push_req = w_wr_data & ~r_flush;
  // A push into a full FIFO is still accepted when a pop frees a slot
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (r_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + ptr_t'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ptr_t'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky status flags: a new event in the clearing read's cycle survives
  // --------------------------------------------------------------------------
  logic r_underrun;
  logic r_overflow;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_underrun <= w_core_urun | (r_underrun & ~w_rd_status);
      r_overflow <= w_ovf_set   | (r_overflow & ~w_rd_status);
    end
  end

  // --------------------------------------------------------------------------
  // Serializer
  // --------------------------------------------------------------------------
  i2s_tx_core #(
    .CLK_DIV (CLK_DIV)
  ) u_core (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .i_en         (r_ctrl.en),
    .i_mono       (r_ctrl.mono),
    .i_fifo_empty (w_empty),
    .i_fifo_data  (r_mem[r_rptr]),
    .o_pop        (w_core_pop),
    .o_underrun   (w_core_urun),
    .o_sck        (SCK),
    .o_ws         (WS),
    .o_sd         (SD)
  );

  // --------------------------------------------------------------------------
  // Interrupt
  // --------------------------------------------------------------------------
  logic r_irq;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ctrl.ie & r_ctrl.en & (w_empty | r_underrun);
    end
  end

  assign IRQ = r_irq;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [c_ST_LEVEL_W-1:0] w_level;
  logic [31:0]             w_status;
  logic [31:0]             w_ctrl_rd;

  assign w_level   = c_ST_LEVEL_W'(r_count);
  assign w_status  = {23'd0, w_level, r_overflow, r_underrun, w_full, w_empty};
  // FLUSH always reads back as 0
  assign w_ctrl_rd = {28'd0, 1'b0, r_ctrl.ie, r_ctrl.mono, r_ctrl.en};

  always_comb begin
    HRDATA = c_UNMAPPED_RD;
    case (r_haddr)
      c_ADDR_CTRL:   HRDATA = w_ctrl_rd;
      c_ADDR_STATUS: HRDATA = w_status;
      c_ADDR_DATA:   HRDATA = 32'h0;
      default:       HRDATA = c_UNMAPPED_RD;
    endcase
  end

  assign HREADYOUT = 1'b1;

endmodule : ahbl_i2s_tx
`default_nettype wire
